// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and register map for the AXI4-lite UART pair
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_e;
  localparam logic [31:0] REG_DATA = 32'h0;
  localparam logic [31:0] REG_STATUS = 32'h4;
  localparam int STAT_NONEMPTY = 0;
  localparam int STAT_OVERFLOW = 1;
  localparam int STAT_FRAME_ERR = 2;
  localparam int DATA_VALID_BIT = 8;
endpackage

// File: rtl/axi4_uart_rx_fifo.sv
// fifo: synchronous first-word-fall-through FIFO; a push while full is accepted only alongside a pop
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_push = push && (!full || pop);
    do_pop = pop && !empty;
    wr_d = do_push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d = do_pop ? rd_q + (AW+1)'(1) : rd_q;
    dout = mem[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
endmodule

// File: rtl/axi4_uart_rx.sv
// axi4_uart_rx: oversampling 8N1 receiver with RX FIFO and sticky errors behind an AXI4-lite slave
module axi4_uart_rx
  import uart_pkg::*;
#(
  parameter int DIVIDER = 100,
  parameter int FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        rx_irq,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_awaddr,
  input  logic [2:0]  axi_awprot,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [31:0] axi_araddr,
  input  logic [2:0]  axi_arprot,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  output logic [31:0] axi_rdata
);
  localparam int CW = $clog2(DIVIDER);
  localparam logic [CW-1:0] HALF = CW'(DIVIDER / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIVIDER - 1);
  logic rx_m_q, rx_s_q;
  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d;
  logic fe_q, fe_d, ovf_q, ovf_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d, data_word, stat_word;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic tick, push, pop, set_fe, set_ovf, clr;
  logic ar_hs, is_data, is_stat, aw_hs, w_hs, aw_seen, w_seen, both;
  logic [7:0] dout;
  logic empty, full;
  logic unused;
  assign unused = ^{axi_awaddr, axi_awprot, axi_wdata, axi_wstrb, axi_arprot, axi_araddr[31:4], axi_araddr[1:0]};
  fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (~reset),
    .push  (push),
    .din   (sh_q),
    .pop   (pop),
    .dout  (dout),
    .empty (empty),
    .full  (full)
  );
  always_comb begin
    tick = cnt_q == '0;
    state_d = state_q;
    cnt_d = tick ? cnt_q : cnt_q - CW'(1);
    idx_d = idx_q;
    sh_d = sh_q;
    push = 1'b0;
    set_fe = 1'b0;
    case (state_q)
      IDLE: if (!rx_s_q) begin
        state_d = START;
        cnt_d = HALF;
      end
      START: if (tick) begin
        state_d = rx_s_q ? IDLE : DATA;
        cnt_d = FULL;
        idx_d = '0;
      end
      DATA: if (tick) begin
        sh_d = {rx_s_q, sh_q[7:1]};
        cnt_d = FULL;
        idx_d = idx_q + 3'd1;
        state_d = idx_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) begin
        push = rx_s_q;
        set_fe = !rx_s_q;
        state_d = rx_s_q ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: state_d = rx_s_q ? IDLE : WAIT_HIGH;
      default: state_d = IDLE;
    endcase
  end
  // Side effects (pop, sticky clear) happen once, on the address handshake
  always_comb begin
    ar_hs = axi_arvalid && arready_q;
    is_data = ar_hs && axi_araddr[3:2] == REG_DATA[3:2];
    is_stat = ar_hs && axi_araddr[3:2] == REG_STATUS[3:2];
    pop = is_data && !empty;
    clr = is_stat;
    set_ovf = push && full && !pop;
    fe_d = set_fe || (fe_q && !clr);
    ovf_d = set_ovf || (ovf_q && !clr);
    data_word = '0;
    data_word[DATA_VALID_BIT] = !empty;
    data_word[7:0] = empty ? 8'h00 : dout;
    stat_word = '0;
    stat_word[STAT_NONEMPTY] = !empty;
    stat_word[STAT_OVERFLOW] = ovf_q;
    stat_word[STAT_FRAME_ERR] = fe_q;
    rdata_d = !ar_hs ? rdata_q : is_data ? data_word : is_stat ? stat_word : '0;
    rvalid_d = ar_hs || (rvalid_q && !axi_rready);
    arready_d = axi_arvalid && !arready_q && !rvalid_q;
    aw_hs = axi_awvalid && awready_q;
    w_hs = axi_wvalid && wready_q;
    aw_seen = aw_done_q || aw_hs;
    w_seen = w_done_q || w_hs;
    both = aw_seen && w_seen;
    bvalid_d = both || (bvalid_q && !axi_bready);
    aw_done_d = aw_seen && !both;
    w_done_d = w_seen && !both;
    awready_d = axi_awvalid && !awready_q && !aw_done_q && !bvalid_q;
    wready_d = axi_wvalid && !wready_q && !w_done_q && !bvalid_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      fe_q <= 1'b0;
      ovf_q <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      awready_q <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      rx_m_q <= uart_rx;
      rx_s_q <= rx_m_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      fe_q <= fe_d;
      ovf_q <= ovf_d;
      arready_q <= arready_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
      awready_q <= awready_d;
      wready_q <= wready_d;
      bvalid_q <= bvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
    end
  end
  assign rx_irq = !empty || fe_q || ovf_q;
  assign axi_arready = arready_q;
  assign axi_rvalid = rvalid_q;
  assign axi_rdata = rdata_q;
  assign axi_awready = awready_q;
  assign axi_wready = wready_q;
  assign axi_bvalid = bvalid_q;
endmodule
